mem_stage_ctl: RTL and testbench

- MEM-stage controller directly downstream of the EX/MEM pipeline register.
- Turns the registered memory request into a valid/ready data-memory transaction.
- Aligns load data and drives the upstream stall while an access is outstanding.
- Registers the retiring instruction's writeback fields for the MEM/WB / writeback logic.

---
 rtl/mem_stage_ctl.sv | 202 ++++++++++++++++++++
 tb/tb_mem_stage_ctl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_ctl.sv
// MEM-stage controller: turns the EX/MEM memory request into a valid/ready
// data-memory transaction, aligns load data and registers writeback fields.
// Optional MEM_ALIGN_CHECK_EN: misaligned half/word accesses raise o_Exception instead of issuing.
//
// state | meaning
// IDLE  | pass-through retire, or accept a new memory op
// REQ   | request presented, waiting for i_DMem_Req_Ready
// RSP   | load issued, waiting for i_DMem_Rsp_Valid
// DONE  | retire the memory instruction next edge
module mem_stage_ctl #(
    parameter int ADDRESS_WIDTH    = 32,
    parameter int DATA_WIDTH       = 32,
    parameter int REG_ADDR_WIDTH   = 5,
    parameter int MEM_MASK_WIDTH   = 3,
    parameter int FREE_LIST_WIDTH  = 3,
    parameter int CHECKPOINT_WIDTH = 2
) (
    input  logic                        i_Clk,
    input  logic                        i_Reset_n,
    input  logic                        i_Flush,
    input  logic [ADDRESS_WIDTH-1:0]    i_PC,
    input  logic [DATA_WIDTH-1:0]       i_ALU_Result,
    input  logic                        i_Mem_Valid,
    input  logic [MEM_MASK_WIDTH-1:0]   i_Mem_Mask,
    input  logic                        i_Mem_Read_Write_n,
    input  logic [DATA_WIDTH-1:0]       i_Mem_Write_Data,
    input  logic                        i_Writes_Back,
    input  logic [REG_ADDR_WIDTH:0]     i_PWrite_Addr,
    input  logic [FREE_LIST_WIDTH-1:0]  i_Phys_Active_List_Index,
    input  logic [CHECKPOINT_WIDTH-1:0] i_Checkpoint,
    output logic                        o_Stall,
    output logic                        o_DMem_Req_Valid,
    input  logic                        i_DMem_Req_Ready,
    output logic [ADDRESS_WIDTH-1:0]    o_DMem_Addr,
    output logic                        o_DMem_Read_Write_n,
    output logic [3:0]                  o_DMem_Byte_En,
    output logic [DATA_WIDTH-1:0]       o_DMem_Write_Data,
    input  logic                        i_DMem_Rsp_Valid,
    input  logic [DATA_WIDTH-1:0]       i_DMem_Rsp_Data,
    output logic                        o_Retire,
    output logic [ADDRESS_WIDTH-1:0]    o_PC,
    output logic [DATA_WIDTH-1:0]       o_WB_Data,
    output logic                        o_Writes_Back,
    output logic [REG_ADDR_WIDTH:0]     o_PWrite_Addr,
    output logic [FREE_LIST_WIDTH-1:0]  o_Phys_Active_List_Index,
    output logic [CHECKPOINT_WIDTH-1:0] o_Checkpoint
`ifdef MEM_ALIGN_CHECK_EN
    ,
    output logic                        o_Exception
`endif
);

    typedef enum logic [1:0] {IDLE, REQ, RSP, DONE} state_t;

    state_t state, next_state;
    logic   retire_en;

    logic        kill_q, exc_q, rw_q, uns_q;
    logic [1:0]  size_q, a_q;
    logic [DATA_WIDTH-1:0] ld_q;

    logic [1:0]  a_c, size_c;
    logic [3:0]  be_c;
    logic [DATA_WIDTH-1:0] wdata_c, ld_c;
    logic        misaligned;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    assign a_c    = i_ALU_Result[1:0];
    assign size_c = i_Mem_Mask[1:0];

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = ((size_c == 2'b01) && a_c[0]) || (size_c[1] && (a_c != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    always_comb begin
        be_c    = 4'b1111;
        wdata_c = i_Mem_Write_Data;
        case (size_c)
            2'b00: begin
                be_c    = 4'b0001 << a_c;
                wdata_c = {4{i_Mem_Write_Data[7:0]}};
            end
            2'b01: begin
                be_c    = a_c[1] ? 4'b1100 : 4'b0011;
                wdata_c = {2{i_Mem_Write_Data[15:0]}};
            end
            default: ;
        endcase
    end

    // Load alignment uses the address bits captured when the request was accepted.
    always_comb begin
        case (a_q)
            2'b00:   lane_b = i_DMem_Rsp_Data[7:0];
            2'b01:   lane_b = i_DMem_Rsp_Data[15:8];
            2'b10:   lane_b = i_DMem_Rsp_Data[23:16];
            default: lane_b = i_DMem_Rsp_Data[31:24];
        endcase
        lane_h = a_q[1] ? i_DMem_Rsp_Data[31:16] : i_DMem_Rsp_Data[15:0];
        case (size_q)
            2'b00:   ld_c = uns_q ? {24'b0, lane_b} : {{24{lane_b[7]}}, lane_b};
            2'b01:   ld_c = uns_q ? {16'b0, lane_h} : {{16{lane_h[15]}}, lane_h};
            default: ld_c = i_DMem_Rsp_Data;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) state <= IDLE;
        else            state <= next_state;
    end

    always_comb begin
        next_state       = state;
        o_Stall          = 1'b0;
        o_DMem_Req_Valid = 1'b0;
        retire_en        = 1'b0;
        case (state)
            IDLE: begin
                if (i_Mem_Valid) begin
                    o_Stall    = 1'b1;
                    next_state = (i_Flush || misaligned) ? DONE : REQ;
                end else begin
                    retire_en = 1'b1;
                end
            end
            REQ: begin
                o_Stall          = 1'b1;
                o_DMem_Req_Valid = 1'b1;
                if (i_DMem_Req_Ready) next_state = rw_q ? RSP : DONE;
            end
            RSP: begin
                o_Stall = 1'b1;
                if (i_DMem_Rsp_Valid) next_state = DONE;
            end
            DONE: begin
                retire_en  = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            kill_q <= 1'b0; exc_q <= 1'b0; rw_q <= 1'b0; uns_q <= 1'b0;
            size_q <= '0; a_q <= '0; ld_q <= '0;
            o_DMem_Addr <= '0; o_DMem_Read_Write_n <= 1'b0;
            o_DMem_Byte_En <= '0; o_DMem_Write_Data <= '0;
        end else begin
            if (state == IDLE && i_Mem_Valid) begin
                kill_q              <= i_Flush || misaligned;
                exc_q               <= misaligned;
                rw_q                <= i_Mem_Read_Write_n;
                uns_q               <= i_Mem_Mask[2];
                size_q              <= size_c;
                a_q                 <= a_c;
                o_DMem_Addr         <= {i_ALU_Result[ADDRESS_WIDTH-1:2], 2'b00};
                o_DMem_Read_Write_n <= i_Mem_Read_Write_n;
                o_DMem_Byte_En      <= be_c;
                o_DMem_Write_Data   <= wdata_c;
            end
            if ((state == REQ || state == RSP) && i_Flush) kill_q <= 1'b1;
            if (state == RSP && i_DMem_Rsp_Valid) ld_q <= ld_c;
        end
    end

    // Writeback register: bubbles clear retire/write-enable and hold everything else.
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            o_Retire <= 1'b0; o_Writes_Back <= 1'b0;
            o_PC <= '0; o_WB_Data <= '0; o_PWrite_Addr <= '0;
            o_Phys_Active_List_Index <= '0; o_Checkpoint <= '0;
        end else begin
            o_Retire      <= retire_en;
            o_Writes_Back <= 1'b0;
            if (retire_en) begin
                o_PC                     <= i_PC;
                o_PWrite_Addr            <= i_PWrite_Addr;
                o_Phys_Active_List_Index <= i_Phys_Active_List_Index;
                o_Checkpoint             <= i_Checkpoint;
                if (state == IDLE) begin
                    o_WB_Data     <= i_ALU_Result;
                    o_Writes_Back <= i_Writes_Back && !i_Flush;
                end else begin
                    o_WB_Data     <= rw_q ? ld_q : i_ALU_Result;
                    o_Writes_Back <= i_Writes_Back && rw_q && !kill_q && !i_Flush;
                end
            end
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) o_Exception <= 1'b0;
        else            o_Exception <= retire_en && (state == DONE) && exc_q;
    end
`endif

endmodule

// File: tb/tb_mem_stage_ctl.sv
// Directed self-checking bench for mem_stage_ctl (default build; MEM_ALIGN_CHECK_EN adds the exception case).
module tb_mem_stage_ctl;

    logic        i_Clk = 1'b0;
    logic        i_Reset_n, i_Flush, i_Mem_Valid, i_Mem_Read_Write_n, i_Writes_Back;
    logic [31:0] i_PC, i_ALU_Result, i_Mem_Write_Data, i_DMem_Rsp_Data;
    logic [2:0]  i_Mem_Mask, i_Phys_Active_List_Index;
    logic [5:0]  i_PWrite_Addr;
    logic [1:0]  i_Checkpoint;
    logic        i_DMem_Req_Ready, i_DMem_Rsp_Valid;
    logic        o_Stall, o_DMem_Req_Valid, o_DMem_Read_Write_n, o_Retire, o_Writes_Back;
    logic [31:0] o_DMem_Addr, o_DMem_Write_Data, o_PC, o_WB_Data;
    logic [3:0]  o_DMem_Byte_En;
    logic [5:0]  o_PWrite_Addr;
    logic [2:0]  o_Phys_Active_List_Index;
    logic [1:0]  o_Checkpoint;
`ifdef MEM_ALIGN_CHECK_EN
    logic        o_Exception;
`endif

    always #5 i_Clk = ~i_Clk;

    mem_stage_ctl dut (
        .i_Clk(i_Clk), .i_Reset_n(i_Reset_n), .i_Flush(i_Flush), .i_PC(i_PC),
        .i_ALU_Result(i_ALU_Result), .i_Mem_Valid(i_Mem_Valid), .i_Mem_Mask(i_Mem_Mask),
        .i_Mem_Read_Write_n(i_Mem_Read_Write_n), .i_Mem_Write_Data(i_Mem_Write_Data),
        .i_Writes_Back(i_Writes_Back), .i_PWrite_Addr(i_PWrite_Addr),
        .i_Phys_Active_List_Index(i_Phys_Active_List_Index), .i_Checkpoint(i_Checkpoint),
        .o_Stall(o_Stall), .o_DMem_Req_Valid(o_DMem_Req_Valid), .i_DMem_Req_Ready(i_DMem_Req_Ready),
        .o_DMem_Addr(o_DMem_Addr), .o_DMem_Read_Write_n(o_DMem_Read_Write_n),
        .o_DMem_Byte_En(o_DMem_Byte_En), .o_DMem_Write_Data(o_DMem_Write_Data),
        .i_DMem_Rsp_Valid(i_DMem_Rsp_Valid), .i_DMem_Rsp_Data(i_DMem_Rsp_Data),
        .o_Retire(o_Retire), .o_PC(o_PC), .o_WB_Data(o_WB_Data), .o_Writes_Back(o_Writes_Back),
        .o_PWrite_Addr(o_PWrite_Addr), .o_Phys_Active_List_Index(o_Phys_Active_List_Index),
        .o_Checkpoint(o_Checkpoint)
`ifdef MEM_ALIGN_CHECK_EN
        , .o_Exception(o_Exception)
`endif
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_Clk);
        #1;
    endtask

    // Results of the last mem_op
    int          r_stalls, r_lat, r_reqs;
    logic [31:0] r_addr, r_wdata;
    logic [3:0]  r_be;
    logic        r_rw, r_wb, r_retired, r_bubble_bad, r_exc;
    logic [31:0] r_wbdata;

    task automatic mem_op(input logic [31:0] addr, input logic [2:0] mask, input logic rw,
                          input logic [31:0] wd, input logic [31:0] rsp, input int req_wait,
                          input logic flush_rsp);
        logic hs, hs_now;
        hs = 1'b0; r_stalls = 0; r_lat = 0; r_reqs = 0; r_retired = 1'b0;
        r_bubble_bad = 1'b0; r_exc = 1'b0; r_addr = '0; r_wdata = '0; r_be = '0; r_rw = 1'b0;
        i_Mem_Valid = 1'b1; i_ALU_Result = addr; i_Mem_Mask = mask; i_Mem_Read_Write_n = rw;
        i_Mem_Write_Data = wd; i_Writes_Back = 1'b1; i_DMem_Rsp_Data = rsp;
        for (int c = 0; c < 30 && !r_retired; c++) begin
            i_DMem_Req_Ready = o_DMem_Req_Valid && (r_reqs == req_wait);
            i_DMem_Rsp_Valid = hs;
            i_Flush          = flush_rsp && hs;
            #1;
            if (o_Stall) r_stalls++;
            if (o_DMem_Req_Valid) begin
                r_addr = o_DMem_Addr; r_wdata = o_DMem_Write_Data;
                r_be = o_DMem_Byte_En; r_rw = o_DMem_Read_Write_n;
                r_reqs++;
            end
            hs_now = o_DMem_Req_Valid && i_DMem_Req_Ready;
            @(posedge i_Clk);
            #1;
            r_lat++;
            hs = hs_now && rw;
            if (o_Retire) begin
                r_retired = 1'b1; r_wb = o_Writes_Back; r_wbdata = o_WB_Data;
`ifdef MEM_ALIGN_CHECK_EN
                r_exc = o_Exception;
`endif
            end else if (o_Writes_Back) begin
                r_bubble_bad = 1'b1;
            end
        end
        i_Mem_Valid = 1'b0; i_DMem_Req_Ready = 1'b0; i_DMem_Rsp_Valid = 1'b0; i_Flush = 1'b0;
        i_Writes_Back = 1'b0; i_ALU_Result = '0;
        if (!r_retired) chk("retire_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        i_Reset_n = 1'b0; i_Flush = 1'b0; i_Mem_Valid = 1'b0; i_Mem_Read_Write_n = 1'b0;
        i_Writes_Back = 1'b0; i_PC = '0; i_ALU_Result = '0; i_Mem_Write_Data = '0;
        i_DMem_Rsp_Data = '0; i_Mem_Mask = '0; i_Phys_Active_List_Index = '0;
        i_PWrite_Addr = '0; i_Checkpoint = '0; i_DMem_Req_Ready = 1'b0; i_DMem_Rsp_Valid = 1'b0;
        tick(); tick();
        chk("rst_retire", {31'b0, o_Retire}, 32'd0);
        chk("rst_stall", {31'b0, o_Stall}, 32'd0);
        chk("rst_req_valid", {31'b0, o_DMem_Req_Valid}, 32'd0);
        chk("rst_wb_data", o_WB_Data, 32'd0);
        i_Reset_n = 1'b1;
        tick();

        // ALU pass-through
        i_ALU_Result = 32'h1234; i_Writes_Back = 1'b1; i_PC = 32'h400;
        i_PWrite_Addr = 6'h25; i_Phys_Active_List_Index = 3'd5; i_Checkpoint = 2'd2;
        #1;
        chk("add_stall", {31'b0, o_Stall}, 32'd0);
        tick();
        chk("add_retire", {31'b0, o_Retire}, 32'd1);
        chk("add_wb_data", o_WB_Data, 32'h1234);
        chk("add_wb_en", {31'b0, o_Writes_Back}, 32'd1);
        chk("add_pc", o_PC, 32'h400);
        chk("add_pdst", {26'b0, o_PWrite_Addr}, 32'h25);
        chk("add_tag", {27'b0, o_Phys_Active_List_Index, o_Checkpoint}, {27'b0, 3'd5, 2'd2});
        i_Writes_Back = 1'b0;

        // LW 0x100, ready after two wait cycles
        mem_op(32'h100, 3'b010, 1'b1, 32'h0, 32'hDEADBEEF, 2, 1'b0);
        chk("lw_addr", r_addr, 32'h100);
        chk("lw_be", {28'b0, r_be}, 32'hF);
        chk("lw_rw", {31'b0, r_rw}, 32'd1);
        chk("lw_stalls", r_stalls, 32'd5);
        chk("lw_data", r_wbdata, 32'hDEADBEEF);
        chk("lw_wb_en", {31'b0, r_wb}, 32'd1);
        chk("lw_bubble", {31'b0, r_bubble_bad}, 32'd0);

        // Minimum-latency load
        mem_op(32'h103, 3'b000, 1'b1, 32'h0, 32'h80FFFFFF, 0, 1'b0);
        chk("lb_be", {28'b0, r_be}, 32'h8);
        chk("lb_addr", r_addr, 32'h100);
        chk("lb_data", r_wbdata, 32'hFFFFFF80);
        chk("load_min_lat", r_lat, 32'd4);

        mem_op(32'h103, 3'b100, 1'b1, 32'h0, 32'h80FFFFFF, 0, 1'b0);
        chk("lbu_data", r_wbdata, 32'h00000080);

        mem_op(32'h102, 3'b101, 1'b1, 32'h0, 32'h80FFFFFF, 1, 1'b0);
        chk("lhu_be", {28'b0, r_be}, 32'hC);
        chk("lhu_data", r_wbdata, 32'h000080FF);

        mem_op(32'h100, 3'b001, 1'b1, 32'h0, 32'h12348001, 0, 1'b0);
        chk("lh_data", r_wbdata, 32'hFFFF8001);

        // Stores
        mem_op(32'h201, 3'b000, 1'b0, 32'h000000AB, 32'h0, 0, 1'b0);
        chk("sb_wdata", r_wdata, 32'hABABABAB);
        chk("sb_be", {28'b0, r_be}, 32'h2);
        chk("sb_rw", {31'b0, r_rw}, 32'd0);
        chk("sb_addr", r_addr, 32'h200);
        chk("sb_wb_en", {31'b0, r_wb}, 32'd0);
        chk("store_min_lat", r_lat, 32'd3);

        mem_op(32'h202, 3'b001, 1'b0, 32'h0000BEEF, 32'h0, 1, 1'b0);
        chk("sh_wdata", r_wdata, 32'hBEEFBEEF);
        chk("sh_be", {28'b0, r_be}, 32'hC);

        mem_op(32'h300, 3'b010, 1'b0, 32'h11223344, 32'h0, 0, 1'b0);
        chk("sw_wdata", r_wdata, 32'h11223344);
        chk("sw_be", {28'b0, r_be}, 32'hF);

        // Flush while the load response is pending
        mem_op(32'h100, 3'b010, 1'b1, 32'h0, 32'hCAFEF00D, 0, 1'b1);
        chk("flush_retired", {31'b0, r_retired}, 32'd1);
        chk("flush_wb_en", {31'b0, r_wb}, 32'd0);
        chk("flush_reqs", r_reqs, 32'd1);

`ifdef MEM_ALIGN_CHECK_EN
        mem_op(32'h102, 3'b010, 1'b1, 32'h0, 32'h55555555, 0, 1'b0);
        chk("mis_reqs", r_reqs, 32'd0);
        chk("mis_exc", {31'b0, r_exc}, 32'd1);
        chk("mis_wb_en", {31'b0, r_wb}, 32'd0);
        tick();
        chk("mis_exc_pulse", {31'b0, o_Exception}, 32'd0);
`else
        mem_op(32'h102, 3'b010, 1'b1, 32'h0, 32'h55AA33CC, 0, 1'b0);
        chk("unal_w_addr", r_addr, 32'h100);
        chk("unal_w_be", {28'b0, r_be}, 32'hF);
        chk("unal_w_data", r_wbdata, 32'h55AA33CC);
        mem_op(32'h103, 3'b001, 1'b0, 32'h00001234, 32'h0, 0, 1'b0);
        chk("unal_h_be", {28'b0, r_be}, 32'hC);
`endif

        // Asynchronous reset while a request is outstanding
        i_Mem_Valid = 1'b1; i_ALU_Result = 32'h100; i_Mem_Mask = 3'b010; i_Mem_Read_Write_n = 1'b1;
        tick();
        chk("pre_rst_req_valid", {31'b0, o_DMem_Req_Valid}, 32'd1);
        i_Reset_n = 1'b0;
        #1;
        chk("rst_in_req_valid", {31'b0, o_DMem_Req_Valid}, 32'd0);
        i_Mem_Valid = 1'b0;
        #1;
        chk("rst_in_req_stall", {31'b0, o_Stall}, 32'd0);
        tick();
        i_Reset_n = 1'b1;
        i_ALU_Result = 32'h77; i_Writes_Back = 1'b1;
        tick();
        chk("post_rst_idle_retire", {31'b0, o_Retire}, 32'd1);
        chk("post_rst_idle_data", o_WB_Data, 32'h77);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
